// File: rtl/pe_pkg.sv
// Shared opcode encoding for the pipelined accumulating processing element.
package pe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        MUL  = 3'd2,
        MAC  = 3'd3,
        ACC  = 3'd4,
        CLR  = 3'd5,
        RSV6 = 3'd6,
        RSV7 = 3'd7
    } op_t;

endpackage

// File: rtl/pe_acc_if.sv
// Bundle of pe_acc handshake signals with a clocking view for a stimulus/monitor agent.
interface pe_acc_if
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 20
) (
    input logic clk
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_c;
    logic [OP_W-1:0]   op_i;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  result;
    logic              ovf;
    logic              err;

    clocking cb @(posedge clk);
        output in_valid, op_a, op_b, op_c, op_i, out_ready;
        input  in_ready, out_valid, result, ovf, err;
    endclocking

endinterface

// File: rtl/pe_acc_alu.sv
// Stage-2 combinational datapath: computes the result, next accumulator value and flags
// from the stage-1 registers and the current accumulator.
module pe_acc_alu
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 20,
    parameter int SAT    = 1
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W-1:0]   c,
    input  logic [2*DATA_W-1:0] prod,
    input  op_t                 op,
    input  logic [RES_W-1:0]    acc,
    output logic [RES_W-1:0]    result_nxt,
    output logic [RES_W-1:0]    acc_nxt,
    output logic                ovf,
    output logic                err
);

    logic [RES_W-1:0] a_x;
    logic [RES_W-1:0] b_x;
    logic [RES_W-1:0] c_x;
    logic [RES_W-1:0] p_x;
    logic [RES_W:0]   acc_sum;

    assign a_x = RES_W'(a);
    assign b_x = RES_W'(b);
    assign c_x = RES_W'(c);
    assign p_x = RES_W'(prod);

    // One extra bit so the carry out of the accumulator is visible.
    assign acc_sum = {1'b0, acc} + {1'b0, p_x};

    always_comb begin
        result_nxt = '0;
        acc_nxt    = acc;
        ovf        = 1'b0;
        err        = 1'b0;
        case (op)
            ADD: result_nxt = a_x + b_x;
            SUB: result_nxt = a_x - b_x;
            MUL: result_nxt = p_x;
            MAC: result_nxt = p_x + c_x;
            ACC: begin
                ovf = acc_sum[RES_W];
                if (acc_sum[RES_W] && (SAT != 0)) begin
                    acc_nxt = '1;
                end else begin
                    acc_nxt = acc_sum[RES_W-1:0];
                end
                result_nxt = acc_nxt;
            end
            CLR: acc_nxt = '0;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/pe_acc.sv
// Two-stage pipelined PE with valid/ready on both sides and a running accumulator.
// Handshake: a beat transfers on a rising edge where valid && ready; ready never waits on valid.
module pe_acc
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 20,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_c,
    input  logic [OP_W-1:0]   op_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  result,
    output logic              ovf,
    output logic              err
);

    if (DATA_W < 2) begin : g_bad_data_w
        $error("pe_acc: DATA_W must be at least 2");
    end
    if (RES_W < 2 * DATA_W + 1) begin : g_bad_res_w
        $error("pe_acc: RES_W must be at least 2*DATA_W+1");
    end

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_a;
    logic [DATA_W-1:0]   s1_b;
    logic [DATA_W-1:0]   s1_c;
    logic [2*DATA_W-1:0] s1_prod;
    op_t                 s1_op;
    logic [RES_W-1:0]    acc;
    logic [RES_W-1:0]    acc_nxt;
    logic [RES_W-1:0]    result_nxt;
    logic                ovf_nxt;
    logic                err_nxt;
    logic                s1_adv;
    logic                s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_prod  <= '0;
            s1_op    <= ADD;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= op_a;
                s1_b    <= op_b;
                s1_c    <= op_c;
                s1_prod <= (2*DATA_W)'(op_a) * (2*DATA_W)'(op_b);
                s1_op   <= op_t'(op_i);
            end
        end
    end

    pe_acc_alu #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W),
        .SAT    (SAT)
    ) u_alu (
        .a          (s1_a),
        .b          (s1_b),
        .c          (s1_c),
        .prod       (s1_prod),
        .op         (s1_op),
        .acc        (acc),
        .result_nxt (result_nxt),
        .acc_nxt    (acc_nxt),
        .ovf        (ovf_nxt),
        .err        (err_nxt)
    );

    // acc is read and written only here, so each ACC/CLR beat updates it exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= result_nxt;
                ovf    <= ovf_nxt;
                err    <= err_nxt;
                acc    <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pe_acc.sv
// Directed bench for pe_acc: scoreboarded default instance plus 17-bit saturating and wrapping instances.
module tb_pe_acc;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pe_acc_if #(.DATA_W(8), .RES_W(20)) bus (.clk(clk));

    pe_acc #(.DATA_W(8), .RES_W(20), .SAT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(bus.in_valid), .in_ready(bus.in_ready),
        .op_a(bus.op_a), .op_b(bus.op_b), .op_c(bus.op_c), .op_i(bus.op_i),
        .out_valid(bus.out_valid), .out_ready(bus.out_ready),
        .result(bus.result), .ovf(bus.ovf), .err(bus.err)
    );

    logic        s_valid;
    logic [7:0]  s_a, s_b, s_c;
    logic [2:0]  s_op;
    logic        sat_ready, sat_ov, sat_ovf, sat_err;
    logic [16:0] sat_res;
    logic        wrap_ready, wrap_ov, wrap_ovf, wrap_err;
    logic [16:0] wrap_res;

    pe_acc #(.DATA_W(8), .RES_W(17), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(sat_ready),
        .op_a(s_a), .op_b(s_b), .op_c(s_c), .op_i(s_op),
        .out_valid(sat_ov), .out_ready(1'b1),
        .result(sat_res), .ovf(sat_ovf), .err(sat_err)
    );

    pe_acc #(.DATA_W(8), .RES_W(17), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(wrap_ready),
        .op_a(s_a), .op_b(s_b), .op_c(s_c), .op_i(s_op),
        .out_valid(wrap_ov), .out_ready(1'b1),
        .result(wrap_res), .ovf(wrap_ovf), .err(wrap_err)
    );

    // Scoreboards
    logic [19:0] exp_q[$];
    logic [1:0]  flag_q[$];
    int          stamp_q[$];
    logic [16:0] sat_q[$];
    logic        sat_ovf_q[$];
    logic [16:0] wrap_q[$];
    logic        wrap_ovf_q[$];

    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    int   delivered = 0;
    bit   mon_on = 1'b0;
    bit   lat_chk = 1'b0;
    bit   bp_on = 1'b0;
    int   bp_idx = 0;
    logic bp_pat[4];
    bit   prev_stall = 1'b0;
    logic [19:0] prev_result = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bp_on) begin
            bus.out_ready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end
    endtask

    task automatic send(input op_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [19:0] er,
                        input logic eo, input logic ee);
        bit done;
        done = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.op_i = op;
        bus.op_a = a;
        bus.op_b = b;
        bus.op_c = c;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (bus.in_ready) begin
                exp_q.push_back(er);
                flag_q.push_back({eo, ee});
                stamp_q.push_back(cyc);
                @(posedge clk);
                accepted++;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        if (!done) chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic idle();
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (exp_q.size() + sat_q.size() + wrap_q.size()) != 0; n++) tick();
        chk("drain_left", 32'(exp_q.size() + sat_q.size() + wrap_q.size()), 32'd0);
    endtask

    // Output monitor, sampled 1 time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (mon_on) begin
            chk("in_ready", 32'(bus.in_ready),
                32'(!((accepted - delivered) == 2 && !bus.out_ready)));
            if (prev_stall) begin
                chk("hold_result", 32'(bus.result), 32'(prev_result));
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    logic [19:0] er;
                    logic [1:0]  ef;
                    int          st;
                    er = exp_q.pop_front();
                    ef = flag_q.pop_front();
                    st = stamp_q.pop_front();
                    chk("result", 32'(bus.result), 32'(er));
                    chk("ovf", 32'(bus.ovf), 32'(ef[1]));
                    chk("err", 32'(bus.err), 32'(ef[0]));
                    if (lat_chk) chk("latency", 32'(cyc - st), 32'd2);
                end
                delivered++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_result = bus.result;
            if (sat_ov) begin
                if (sat_q.size() == 0) chk("sat_spurious", 32'(sat_ov), 32'd0);
                else begin
                    chk("sat_result", 32'(sat_res), 32'(sat_q.pop_front()));
                    chk("sat_ovf", 32'(sat_ovf), 32'(sat_ovf_q.pop_front()));
                end
            end
            if (wrap_ov) begin
                if (wrap_q.size() == 0) chk("wrap_spurious", 32'(wrap_ov), 32'd0);
                else begin
                    chk("wrap_result", 32'(wrap_res), 32'(wrap_q.pop_front()));
                    chk("wrap_ovf", 32'(wrap_ovf), 32'(wrap_ovf_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [16:0] sat_exp[3];
        logic [16:0] wrap_exp[3];
        logic        ovf_exp[3];
        logic [7:0]  ra, rb;

        bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;
        sat_exp[0] = 17'd65025; sat_exp[1] = 17'd130050; sat_exp[2] = 17'd131071;
        wrap_exp[0] = 17'd65025; wrap_exp[1] = 17'd130050; wrap_exp[2] = 17'd64003;
        ovf_exp[0] = 1'b0; ovf_exp[1] = 1'b0; ovf_exp[2] = 1'b1;

        // Reset: in_valid asserted during reset must not be accepted.
        bus.in_valid = 1'b1; bus.op_i = ADD; bus.op_a = 8'd1; bus.op_b = 8'd1; bus.op_c = 8'd0;
        bus.out_ready = 1'b1;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_c = '0; s_op = ADD;
        rst = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_acc", 32'(dut.acc), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        mon_on = 1'b1;

        // Basic operations
        lat_chk = 1'b1;
        send(ADD, 8'd200, 8'd100, 8'd0, 20'd300, 1'b0, 1'b0);
        send(SUB, 8'd3, 8'd5, 8'd0, 20'hFFFFE, 1'b0, 1'b0);
        send(MUL, 8'd255, 8'd255, 8'd0, 20'd65025, 1'b0, 1'b0);
        send(MAC, 8'd255, 8'd255, 8'd255, 20'd65280, 1'b0, 1'b0);
        idle();
        drain();

        // Back-to-back accumulate
        send(CLR, 8'd0, 8'd0, 8'd0, 20'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) send(ACC, 8'd10, 8'd10, 8'd0, 20'(100 * i), 1'b0, 1'b0);
        idle();
        drain();

        // Reserved opcode leaves acc alone
        send(CLR, 8'd0, 8'd0, 8'd0, 20'd0, 1'b0, 1'b0);
        send(ACC, 8'd2, 8'd3, 8'd0, 20'd6, 1'b0, 1'b0);
        send(RSV6, 8'd1, 8'd1, 8'd0, 20'd0, 1'b0, 1'b1);
        send(ACC, 8'd1, 8'd1, 8'd0, 20'd7, 1'b0, 1'b0);
        idle();
        drain();

        // Backpressure with out_ready pattern 1,0,0,1
        lat_chk = 1'b0;
        bp_on = 1'b1;
        bp_idx = 0;
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ADD, ra, rb, 8'd0, 20'(ra) + 20'(rb), 1'b0, 1'b0);
        end
        idle();
        drain();
        bp_on = 1'b0;
        tick();
        bus.out_ready = 1'b1;

        // Saturating and wrapping accumulators at RES_W=17
        tick();
        s_valid = 1'b1; s_op = ACC; s_a = 8'd255; s_b = 8'd255;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sw_in_ready", 32'(sat_ready && wrap_ready), 32'd1);
            sat_q.push_back(sat_exp[i]);
            sat_ovf_q.push_back(ovf_exp[i]);
            wrap_q.push_back(wrap_exp[i]);
            wrap_ovf_q.push_back(ovf_exp[i]);
            tick();
        end
        s_valid = 1'b0;
        drain();

        // Reset with two beats in flight
        lat_chk = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        send(ACC, 8'd2, 8'd2, 8'd0, 20'd11, 1'b0, 1'b0);
        send(ACC, 8'd2, 8'd2, 8'd0, 20'd15, 1'b0, 1'b0);
        idle();
        #2;
        mon_on = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_acc", 32'(dut.acc), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        flag_q.delete();
        stamp_q.delete();
        accepted = 0;
        delivered = 0;
        prev_stall = 1'b0;
        bus.out_ready = 1'b1;
        mon_on = 1'b1;
        send(ACC, 8'd1, 8'd1, 8'd0, 20'd1, 1'b0, 1'b0);
        idle();
        drain();
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
